// File: rtl/riscv_pkg.sv
// riscv_pkg: widths, ALU operation codes and the EX control bundle shared by
// the pipeline stages.
package riscv_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SRA = 4'b0101,
        OP_SLL = 4'b0110,
        OP_SRL = 4'b0111,
        OP_EQ  = 4'b1000,
        OP_SLT = 4'b1001
    } alu_op_t;

    // Control bits carried from decode into EX and beyond.
    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    alu_src;
        alu_op_t operation;
    } ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: operand bypass for one source register. The MEM producer is the
// youngest result and wins over WB; x0 is never bypassed.
module fwd_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0] held_data,
    input  logic                  mem_we,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_hit,
    output logic [DATA_WIDTH-1:0] data
);

    logic mem_hit;

    assign mem_hit = mem_we && (mem_rd != '0) && (mem_rd == src_addr);
    assign wb_hit  = wb_we  && (wb_rd  != '0) && (wb_rd  == src_addr);

    // Select MEM result, else WB result, else the held register value.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        data = held_data;
        if (mem_hit) begin
            data = mem_data;
        end else if (wb_hit) begin
            data = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with valid/ready handshake, EX/MEM and
// MEM/WB operand forwarding, load-use bubble insertion and branch flush.
// Optional build macro ID_EX_STATS_EN adds stall_count and bubble_count ports.
module id_ex_stage #(
    parameter int DATA_WIDTH    = riscv_pkg::DATA_WIDTH,
    parameter int OPCODE_LENGTH = riscv_pkg::ALU_OP_W,
    parameter int REG_ADDR_W    = riscv_pkg::REG_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [REG_ADDR_W-1:0]    in_rs1_addr,
    input  logic [REG_ADDR_W-1:0]    in_rs2_addr,
    input  logic [REG_ADDR_W-1:0]    in_rd_addr,
    input  logic [DATA_WIDTH-1:0]    in_rs1_data,
    input  logic [DATA_WIDTH-1:0]    in_rs2_data,
    input  logic [DATA_WIDTH-1:0]    in_imm,
    input  logic                     in_uses_rs2,
    input  logic                     in_alu_src,
    input  logic [OPCODE_LENGTH-1:0] in_operation,
    input  logic                     in_reg_write,
    input  logic                     in_mem_read,
    input  logic                     in_mem_write,
    input  logic                     in_branch,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    store_data,
    output logic [REG_ADDR_W-1:0]    rd_addr,
    output logic                     reg_write,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     branch,
    input  logic                     fwd_mem_we,
    input  logic                     fwd_wb_we,
    input  logic [REG_ADDR_W-1:0]    fwd_mem_rd,
    input  logic [REG_ADDR_W-1:0]    fwd_wb_rd,
    input  logic [DATA_WIDTH-1:0]    fwd_mem_data,
    input  logic [DATA_WIDTH-1:0]    fwd_wb_data
`ifdef ID_EX_STATS_EN
    ,
    output logic [31:0]              stall_count,
    output logic [31:0]              bubble_count
`endif
);

    import riscv_pkg::*;

    logic                  valid_q;
    ex_ctrl_t              ctrl_q;
    ex_ctrl_t              in_ctrl;
    logic [REG_ADDR_W-1:0] rs1_q;
    logic [REG_ADDR_W-1:0] rs2_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_WIDTH-1:0] rs1_data_q;
    logic [DATA_WIDTH-1:0] rs2_data_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [DATA_WIDTH-1:0] rs1_fwd;
    logic [DATA_WIDTH-1:0] rs2_fwd;
    logic                  rs1_wb_hit;
    logic                  rs2_wb_hit;
    logic                  hazard;
    logic                  accept;

    assign in_ctrl = '{
        reg_write: in_reg_write,
        mem_read:  in_mem_read,
        mem_write: in_mem_write,
        branch:    in_branch,
        alu_src:   in_alu_src,
        operation: alu_op_t'(in_operation[ALU_OP_W-1:0])
    };

    // A held load whose rd feeds the incoming instruction cannot forward yet.
    assign hazard = valid_q && ctrl_q.mem_read && (rd_q != '0) && in_valid &&
                    ((rd_q == in_rs1_addr) || (in_uses_rs2 && (rd_q == in_rs2_addr)));

    // Flush always consumes the incoming instruction so decode never stalls on it.
    assign in_ready = flush || ((!valid_q || out_ready) && !hazard);
    assign accept   = in_valid && in_ready && !flush;

    // Stage register: flush, then load, then drain, else hold with WB refresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q    <= 1'b1;
            ctrl_q     <= in_ctrl;
            rs1_q      <= in_rs1_addr;
            rs2_q      <= in_rs2_addr;
            rd_q       <= in_rd_addr;
            rs1_data_q <= in_rs1_data;
            rs2_data_q <= in_rs2_data;
            imm_q      <= in_imm;
        end else begin
            if (out_ready) begin
                valid_q <= 1'b0;
            end
            // Capture write-backs while held so a long stall never loses them.
            if (valid_q && rs1_wb_hit) begin
                rs1_data_q <= fwd_wb_data;
            end
            if (valid_q && rs2_wb_hit) begin
                rs2_data_q <= fwd_wb_data;
            end
        end
    end

    fwd_mux #(
        .DATA_WIDTH(DATA_WIDTH),
        .REG_ADDR_W(REG_ADDR_W)
    ) u_fwd_rs1 (
        .src_addr (rs1_q),
        .held_data(rs1_data_q),
        .mem_we   (fwd_mem_we),
        .mem_rd   (fwd_mem_rd),
        .mem_data (fwd_mem_data),
        .wb_we    (fwd_wb_we),
        .wb_rd    (fwd_wb_rd),
        .wb_data  (fwd_wb_data),
        .wb_hit   (rs1_wb_hit),
        .data     (rs1_fwd)
    );

    fwd_mux #(
        .DATA_WIDTH(DATA_WIDTH),
        .REG_ADDR_W(REG_ADDR_W)
    ) u_fwd_rs2 (
        .src_addr (rs2_q),
        .held_data(rs2_data_q),
        .mem_we   (fwd_mem_we),
        .mem_rd   (fwd_mem_rd),
        .mem_data (fwd_mem_data),
        .wb_we    (fwd_wb_we),
        .wb_rd    (fwd_wb_rd),
        .wb_data  (fwd_wb_data),
        .wb_hit   (rs2_wb_hit),
        .data     (rs2_fwd)
    );

    assign out_valid  = valid_q;
    assign SrcA       = rs1_fwd;
    assign SrcB       = ctrl_q.alu_src ? imm_q : rs2_fwd;
    assign store_data = rs2_fwd;
    assign Operation  = OPCODE_LENGTH'(ctrl_q.operation);
    assign rd_addr    = rd_q;
    assign reg_write  = valid_q && ctrl_q.reg_write;
    assign mem_read   = valid_q && ctrl_q.mem_read;
    assign mem_write  = valid_q && ctrl_q.mem_write;
    assign branch     = valid_q && ctrl_q.branch;

`ifdef ID_EX_STATS_EN
    // Free-running stall and bubble counters, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (in_valid && !in_ready) begin
                stall_count <= stall_count + 32'd1;
            end
            if (hazard && out_ready && !flush) begin
                bubble_count <= bubble_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage. Each cycle the stimulus
// side pushes the expected outputs from a behavioural model; a monitor pops
// and compares on the falling edge. Honours ID_EX_STATS_EN when defined.
module tb_id_ex_stage;

    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic        in_uses_rs2, in_alu_src;
    logic [3:0]  in_operation;
    logic        in_reg_write, in_mem_read, in_mem_write, in_branch;
    logic        flush, out_valid, out_ready;
    logic [31:0] SrcA, SrcB, store_data;
    logic [3:0]  Operation;
    logic [4:0]  rd_addr;
    logic        reg_write, mem_read, mem_write, branch;
    logic        fwd_mem_we, fwd_wb_we;
    logic [4:0]  fwd_mem_rd, fwd_wb_rd;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic [31:0] stall_count, bubble_count;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_uses_rs2(in_uses_rs2), .in_alu_src(in_alu_src), .in_operation(in_operation),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_branch(in_branch),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .store_data(store_data),
        .rd_addr(rd_addr), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch),
        .fwd_mem_we(fwd_mem_we), .fwd_wb_we(fwd_wb_we),
        .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd),
        .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data)
`ifdef ID_EX_STATS_EN
        ,
        .stall_count(stall_count), .bubble_count(bubble_count)
`endif
    );

`ifndef ID_EX_STATS_EN
    assign stall_count  = 32'd0;
    assign bubble_count = 32'd0;
`endif

    // Instruction as held by the model.
    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] v1, v2, imm;
        logic        alu_src;
        logic [3:0]  op;
        logic        rw, mr, mw, br;
    } ent_t;

    // Expected DUT outputs for one cycle.
    typedef struct {
        logic        valid, rdy;
        logic [31:0] a, b, sd;
        logic [3:0]  op, ctrl;
        logic [4:0]  rd;
        logic [31:0] sc, bc;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    ent_t        held;
    logic        held_valid = 1'b0;
    logic [31:0] stall_exp = 32'd0;
    logic [31:0] bubble_exp = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural view of a source operand: youngest in-flight producer wins.
    function automatic logic [31:0] fwd_model(input logic [4:0] r, input logic [31:0] held_val);
        if (r == 5'd0) return held_val;
        if (fwd_mem_we && fwd_mem_rd == r) return fwd_mem_data;
        if (fwd_wb_we && fwd_wb_rd == r) return fwd_wb_data;
        return held_val;
    endfunction

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        fwd_mem_we = 1'b0; fwd_wb_we = 1'b0;
        fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0; fwd_mem_data = 32'd0; fwd_wb_data = 32'd0;
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic [31:0] d1,
                             input logic [4:0] rs2, input logic [31:0] d2,
                             input logic [4:0] rd, input logic [31:0] imm,
                             input logic uses2, input logic asrc, input logic [3:0] op,
                             input logic rw, input logic mr, input logic mw, input logic br);
        in_valid = 1'b1;
        in_rs1_addr = rs1; in_rs1_data = d1; in_rs2_addr = rs2; in_rs2_data = d2;
        in_rd_addr = rd; in_imm = imm; in_uses_rs2 = uses2; in_alu_src = asrc;
        in_operation = op; in_reg_write = rw; in_mem_read = mr;
        in_mem_write = mw; in_branch = br;
    endtask

    task automatic randomize_inputs();
        logic [4:0] r1, r2;
        r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        set_instr(r1, (r1 == 0) ? 32'd0 : $urandom, r2, (r2 == 0) ? 32'd0 : $urandom,
                  5'($urandom_range(0, 7)), $urandom, 1'($urandom), 1'($urandom),
                  4'($urandom_range(0, 9)), 1'($urandom), ($urandom_range(0, 2) == 0),
                  1'($urandom), 1'($urandom));
        in_valid     = ($urandom_range(0, 9) < 7);
        out_ready    = ($urandom_range(0, 3) != 0);
        flush        = ($urandom_range(0, 11) == 0);
        fwd_mem_we   = 1'($urandom);
        fwd_wb_we    = 1'($urandom);
        fwd_mem_rd   = 5'($urandom_range(0, 7));
        fwd_wb_rd    = 5'($urandom_range(0, 7));
        fwd_mem_data = $urandom;
        fwd_wb_data  = $urandom;
    endtask

    // Push this cycle's expected outputs, advance the model, step to the next cycle.
    task automatic cycle();
        exp_t e;
        logic hz, rdy;
        e.valid = held_valid;
        e.a     = fwd_model(held.rs1, held.v1);
        e.sd    = fwd_model(held.rs2, held.v2);
        e.b     = held.alu_src ? held.imm : e.sd;
        e.op    = held.op;
        e.rd    = held.rd;
        e.ctrl  = held_valid ? {held.rw, held.mr, held.mw, held.br} : 4'b0000;
        hz = held_valid && held.mr && held.rd != 5'd0 && in_valid &&
             (held.rd == in_rs1_addr || (in_uses_rs2 && held.rd == in_rs2_addr));
        rdy = flush || ((!held_valid || out_ready) && !hz);
        e.rdy = rdy;
        e.sc  = stall_exp;
        e.bc  = bubble_exp;
        sb.push_back(e);
        if (in_valid && !rdy) stall_exp = stall_exp + 32'd1;
        if (hz && out_ready && !flush) bubble_exp = bubble_exp + 32'd1;
        if (flush) begin
            held_valid = 1'b0;
        end else if (in_valid && rdy) begin
            held_valid = 1'b1;
            held = '{rs1: in_rs1_addr, rs2: in_rs2_addr, rd: in_rd_addr,
                     v1: in_rs1_data, v2: in_rs2_data, imm: in_imm,
                     alu_src: in_alu_src, op: in_operation, rw: in_reg_write,
                     mr: in_mem_read, mw: in_mem_write, br: in_branch};
        end else if (out_ready) begin
            held_valid = 1'b0;
        end else if (held_valid && fwd_wb_we) begin
            // Still held: a register write-back becomes the architectural value.
            if (held.rs1 != 0 && fwd_wb_rd == held.rs1) held.v1 = fwd_wb_data;
            if (held.rs2 != 0 && fwd_wb_rd == held.rs2) held.v2 = fwd_wb_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        held_valid = 1'b0;
        held = '{default: 0};
        stall_exp = 32'd0;
        bubble_exp = 32'd0;
    endtask

    // Monitor: compare the DUT against the oldest expected record each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_valid", 32'(out_valid), 32'(e.valid));
                check("in_ready", 32'(in_ready), 32'(e.rdy));
                check("ctrl", 32'({reg_write, mem_read, mem_write, branch}), 32'(e.ctrl));
                if (e.valid) begin
                    check("SrcA", SrcA, e.a);
                    check("SrcB", SrcB, e.b);
                    check("store_data", store_data, e.sd);
                    check("Operation", 32'(Operation), 32'(e.op));
                    check("rd_addr", 32'(rd_addr), 32'(e.rd));
                end
`ifdef ID_EX_STATS_EN
                check("stall_count", stall_count, e.sc);
                check("bubble_count", bubble_count, e.bc);
`endif
            end
        end
    end

    initial begin
        held = '{default: 0};
        idle();
        set_instr(5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0,
                  1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'hAA;

        // Reset state, with a MEM producer active that must not leak through.
        #12;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst SrcA", SrcA, 32'd0);
        check("rst SrcB", SrcB, 32'd0);
        check("rst store_data", store_data, 32'd0);
        check("rst Operation", 32'(Operation), 32'd0);
        check("rst rd_addr", 32'(rd_addr), 32'd0);
        check("rst ctrl", 32'({reg_write, mem_read, mem_write, branch}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle();

        // ADD x3,x1,x2 with x1=5, x2=7.
        set_instr(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'd0, 1'b1, 1'b0, OP_ADD,
                  1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("add in_ready", 32'(in_ready), 32'd1);
        cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("add out_valid", 32'(out_valid), 32'd1);
        check("add SrcA", SrcA, 32'd5);
        check("add SrcB", SrcB, 32'd7);
        check("add Operation", 32'(Operation), 32'(OP_ADD));
        check("add rd_addr", 32'(rd_addr), 32'd3);
        cycle();

        // Forwarding priority on held rs1=x3.
        set_instr(5'd3, 32'h11, 5'd7, 32'h22, 5'd8, 32'd0, 1'b1, 1'b0, OP_OR,
                  1'b1, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'hAA;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd3; fwd_wb_data  = 32'hBB;
        #1 check("fwd mem", SrcA, 32'hAA);
        fwd_mem_we = 1'b0;
        #1 check("fwd wb", SrcA, 32'hBB);
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0;
        #1 check("fwd x0", SrcA, 32'h11);
        cycle();

        // Backpressure with a WB write to the held rs1.
        set_instr(5'd2, 32'h1, 5'd2, 32'h1, 5'd9, 32'd0, 1'b0, 1'b1, OP_XOR,
                  1'b1, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0; fwd_mem_we = 1'b0;
        fwd_wb_we = 1'b1; fwd_wb_rd = 5'd3; fwd_wb_data = 32'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp SrcA", SrcA, 32'h55);
            cycle();
        end
        in_valid = 1'b0; fwd_wb_we = 1'b0;
        #1 check("bp refresh", SrcA, 32'h55);
        out_ready = 1'b1;
        cycle();

        // Load-use: LW x4 held, SUB x5,x4,x6 must see one bubble.
        set_instr(5'd1, 32'h100, 5'd0, 32'd0, 5'd4, 32'd8, 1'b0, 1'b1, OP_ADD,
                  1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        set_instr(5'd4, 32'd0, 5'd6, 32'h30, 5'd5, 32'd0, 1'b1, 1'b0, OP_SUB,
                  1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("lu stall", 32'(in_ready), 32'd0);
        cycle();
        #1;
        check("lu bubble", 32'(out_valid), 32'd0);
        check("lu ready", 32'(in_ready), 32'd1);
        cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd4; fwd_mem_data = 32'hDEAD;
        #1;
        check("lu out_valid", 32'(out_valid), 32'd1);
        check("lu rd_addr", 32'(rd_addr), 32'd5);
        check("lu SrcA", SrcA, 32'hDEAD);
        check("lu SrcB", SrcB, 32'h30);
        cycle();

        // Flush under stall with a pending incoming instruction.
        fwd_mem_we = 1'b0;
        set_instr(5'd1, 32'h1, 5'd2, 32'h2, 5'd9, 32'd0, 1'b1, 1'b0, OP_AND,
                  1'b1, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0; flush = 1'b1;
        #1 check("flush in_ready", 32'(in_ready), 32'd1);
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        #1 check("flush out_valid", 32'(out_valid), 32'd0);
        cycle();
        check("flush dropped", 32'(out_valid), 32'd0);

        // Randomised traffic.
        for (int n = 0; n < 1500; n++) begin
            randomize_inputs();
            cycle();
        end
        idle();
        cycle();

        // Asynchronous reset between edges while an instruction is held.
        set_instr(5'd1, 32'h77, 5'd2, 32'h88, 5'd6, 32'd0, 1'b1, 1'b0, OP_SLT,
                  1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        #1 check("pre-rst out_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        model_reset();
        check("async out_valid", 32'(out_valid), 32'd0);
        check("async SrcA", SrcA, 32'd0);
`ifdef ID_EX_STATS_EN
        check("async stall_count", stall_count, 32'd0);
        check("async bubble_count", bubble_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle();
        cycle();
        cycle();
        @(negedge clk);
        #1;
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
